// File: rtl/if_stage_if.sv
// Bundle of the fetch-stage pipeline signals between the instruction-fetch
// stage and its neighbours: the ID stage, CP0 and the instruction memory.
//
// Flow control: there is no valid/ready pair. When stall is high, IF holds
// both its PC and the IF/ID register. if_id_valid = 0 marks a bubble that
// ID must not execute. instr_i is a combinational read of the memory at
// pc_o in the same cycle.
interface if_stage_if;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_is_branch;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [4:0]  if_id_exccode;
  logic        if_id_bd;
  logic        if_id_valid;

  // Environment side: ID stage, CP0 and instruction memory
  modport master (
    output stall, redirect_en, redirect_pc, id_is_branch, exc_req, eret, epc,
           instr_i,
    input  pc_o, if_id_pc, if_id_instr, if_id_exccode, if_id_bd, if_id_valid
  );

  // Fetch stage side
  modport slave (
    input  stall, redirect_en, redirect_pc, id_is_branch, exc_req, eret, epc,
           instr_i,
    output pc_o, if_id_pc, if_id_instr, if_id_exccode, if_id_bd, if_id_valid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. This block holds the PC and the IF/ID pipeline
// register. It handles stall, delayed-branch redirect, exception entry,
// eret return and fetch-address error (AdEL) detection.
module if_stage #(
  parameter logic [31:0] PC_INIT      = 32'h0000_3000,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] IM_BASE      = 32'h0000_3000,
  parameter logic [31:0] IM_END       = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.slave   bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [4:0]  if_id_exccode_q, if_id_exccode_d;
  logic        if_id_bd_q, if_id_bd_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        fetch_err;
  logic [31:0] cap_instr;
  logic [4:0]  cap_exccode;

  // Legality check on the address being fetched right now; a bad fetch
  // turns into a zero word tagged AdEL instead of whatever memory returned
  always_comb begin
    fetch_err   = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_END);
    cap_instr   = fetch_err ? 32'h0 : bus.instr_i;
    cap_exccode = fetch_err ? EXC_ADEL : EXC_NONE;
  end

  // Next PC and IF/ID contents; exception beats stall beats eret beats redirect
  always_comb begin
    pc_d            = pc_q;
    if_id_pc_d      = if_id_pc_q;
    if_id_instr_d   = if_id_instr_q;
    if_id_exccode_d = if_id_exccode_q;
    if_id_bd_d      = if_id_bd_q;
    if_id_valid_d   = if_id_valid_q;
    if (bus.exc_req) begin
      pc_d            = HANDLER_ADDR;
      if_id_pc_d      = 32'h0;
      if_id_instr_d   = 32'h0;
      if_id_exccode_d = EXC_NONE;
      if_id_bd_d      = 1'b0;
      if_id_valid_d   = 1'b0;
    end else if (bus.stall) begin
      // hold everything; ID re-asserts any redirect/eret once the stall clears
    end else if (bus.eret) begin
      // eret has no delay slot, so the word fetched alongside it is squashed
      pc_d            = bus.epc;
      if_id_pc_d      = 32'h0;
      if_id_instr_d   = 32'h0;
      if_id_exccode_d = EXC_NONE;
      if_id_bd_d      = 1'b0;
      if_id_valid_d   = 1'b0;
    end else begin
      pc_d            = bus.redirect_en ? bus.redirect_pc : pc_q + 32'd4;
      if_id_pc_d      = pc_q;
      if_id_instr_d   = cap_instr;
      if_id_exccode_d = cap_exccode;
      if_id_bd_d      = bus.id_is_branch;
      if_id_valid_d   = 1'b1;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= PC_INIT;
      if_id_pc_q      <= 32'h0;
      if_id_instr_q   <= 32'h0;
      if_id_exccode_q <= EXC_NONE;
      if_id_bd_q      <= 1'b0;
      if_id_valid_q   <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      if_id_pc_q      <= if_id_pc_d;
      if_id_instr_q   <= if_id_instr_d;
      if_id_exccode_q <= if_id_exccode_d;
      if_id_bd_q      <= if_id_bd_d;
      if_id_valid_q   <= if_id_valid_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.if_id_pc      = if_id_pc_q;
  assign bus.if_id_instr   = if_id_instr_q;
  assign bus.if_id_exccode = if_id_exccode_q;
  assign bus.if_id_bd      = if_id_bd_q;
  assign bus.if_id_valid   = if_id_valid_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core.
- Holds the PC register and drives it to the instruction memory.
- Takes the combinational instruction word back from the instruction memory and registers it with its PC into the IF/ID pipeline register.
- Handles stall, delayed-branch redirect, exception entry to the handler, eret return, and fetch-address exception detection.

Parameters:
PC_INIT, 32'h0000_3000, PC value loaded on reset
HANDLER_ADDR, 32'h0000_4180, exception handler entry address
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_END, 32'h0000_6FFC, highest legal fetch address (4096 words)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard stall from the ID stage; hold PC and IF/ID
redirect_en  input  1  branch/jump taken, resolved in ID
redirect_pc  input  32  branch/jump target
id_is_branch  input  1  instruction currently in ID is a branch/jump (next fetched instruction is its delay slot)
exc_req  input  1  CP0 exception/interrupt accepted; go to handler
eret  input  1  eret in ID; return to epc
epc  input  32  CP0 EPC value
instr_i  input  32  instruction word read from the instruction memory at pc_o
pc_o  output  32  current fetch PC to the instruction memory
if_id_pc  output  32  PC of the instruction in ID
if_id_instr  output  32  instruction in ID
if_id_exccode  output  5  0 = none, 4 = AdEL (fetch address error)
if_id_bd  output  1  instruction in ID is a branch delay slot
if_id_valid  output  1  0 = bubble

Behaviour:
Reset:
- While reset is high, asynchronously: pc_o = PC_INIT.
- All if_id_* outputs = 0, including if_id_valid = 0.
- Reset asserted mid-operation discards any pending redirect, eret or exception with no residue.

Fetch check (combinational on pc_o):
- fetch_err = (pc_o[1:0] != 0) OR (pc_o < IM_BASE) OR (pc_o > IM_END), unsigned 32-bit compares.
- When fetch_err = 1, the IF/ID capture uses instr = 0 and exccode = 4.
- Otherwise the capture uses instr = instr_i and exccode = 0.

Per rising edge, in priority order (first match wins):
1. exc_req:
   - PC <= HANDLER_ADDR.
   - IF/ID <= bubble: pc = 0, instr = 0, exccode = 0, bd = 0, valid = 0.
   - Overrides stall, eret and redirect.
2. stall:
   - PC and all IF/ID outputs hold.
   - redirect_en and eret are ignored this cycle; ID keeps the instruction and re-asserts them.
3. eret:
   - PC <= epc.
   - IF/ID <= bubble; eret has no delay slot, so the instruction fetched this cycle is squashed.
4. redirect_en:
   - PC <= redirect_pc.
   - IF/ID <= normal capture; the delay slot is kept.
5. Otherwise:
   - PC <= PC + 4, with 32-bit wrap.
   - IF/ID <= normal capture.

Normal capture:
- if_id_pc <= pc_o.
- if_id_instr and if_id_exccode come from the fetch check.
- if_id_bd <= id_is_branch.
- if_id_valid <= 1.

Timing and arithmetic:
- Latency: the instruction at pc_o appears on if_id_* one cycle later.
- pc_o is the register output directly, with no combinational path from inputs.
- redirect_pc and epc are loaded unmodified, even if misaligned or out of range. The error is flagged on the next capture, and PC continues +4 from the bad value until an exception redirects it.
- Simultaneous redirect_en and eret cannot occur legally; if they do, eret wins per the priority order.
- If id_is_branch is high while eret is asserted, the bubble still forces bd = 0.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> pc_o = 0x3000 immediately, if_id_valid = 0. Release reset, one edge -> if_id_pc = 0x3000, if_id_instr = IM[0], pc_o = 0x3004, valid = 1.
- Branch with delay slot: at pc_o = 0x3008 assert redirect_en = 1, redirect_pc = 0x3100, id_is_branch = 1 -> next cycle if_id_pc = 0x3008, if_id_bd = 1, pc_o = 0x3100. The cycle after, if_id_pc = 0x3100, bd = 0.
- Stall: hold stall = 1 for 3 cycles at pc_o = 0x3010, with redirect_en = 1 also asserted -> pc_o stays 0x3010 and IF/ID is unchanged all 3 cycles. On release, PC takes the redirect.
- Exception during stall: stall = 1 and exc_req = 1 at pc_o = 0x3020 -> next cycle pc_o = 0x4180, if_id_valid = 0, if_id_instr = 0. Following cycle if_id_pc = 0x4180.
- Eret: eret = 1, epc = 0x3044 at pc_o = 0x4190 -> pc_o = 0x3044 and IF/ID is a bubble. Next cycle if_id_pc = 0x3044, exccode = 0.
- Fetch errors:
  - redirect_pc = 0x3002 -> next capture has if_id_exccode = 4, if_id_instr = 0, if_id_pc = 0x3002.
  - Repeat with redirect_pc = 0x7000 and with 0x2FFC -> exccode = 4 each time.
  - PC 0x6FFC -> exccode = 0.
